axi_rd_arbiter: RTL and testbench
=================================

// Module: axi_rd_arbiter
// PURPOSE
//  Shares one AXI read channel (AR/R) between the icache refill port and the data port.
//  Sits between cache/core and the AXI bridge:
//   - arbitrates AR issue and tags each request with a fixed arid;
//   - steers returning R beats back to the owner by rid.
//  At most one request outstanding per requester.
//  A starvation guard keeps data-priority from locking out instruction refill.
// PARAMETERS
//  IC_BURST_LEN  4  beats per icache line refill (arlen = IC_BURST_LEN-1)
//  STARVE_LIMIT  4  consecutive data grants over a pending inst request before inst is forced
// PORTS
//  clk           in   1   single clock, all state on posedge
//  reset         in   1   asynchronous, active-high
//  ic_rd_req     in   1   icache refill request
//  ic_rd_type    in   3   3'b100 line refill; any other value is treated as a single word
//  ic_rd_addr    in   32  refill address (line aligned for 3'b100)
//  ic_rd_rdy     out  1   request accepted this cycle
//  ic_ret_valid  out  1   refill beat valid
//  ic_ret_last   out  1   last refill beat
//  ic_ret_data   out  32  refill beat data
//  d_req         in   1   data read request
//  d_size        in   2   0/1/2 = byte/half/word
//  d_addr        in   32  data read address
//  d_addr_ok     out  1   data request accepted this cycle
//  d_data_ok     out  1   data return valid
//  d_rdata       out  32  data return
//  arid          out  4   0 = icache, 1 = data
//  araddr        out  32  latched request address
//  arlen         out  8   IC_BURST_LEN-1 for a line refill, else 0
//  arsize        out  3   inst 3'b010; data {1'b0,d_size}
//  arvalid       out  1   AR valid
//  arready       in   1   AR ready
//  rid           in   4   R id
//  rdata         in   32  R data
//  rlast         in   1   R last
//  rvalid        in   1   R valid
//  rready        out  1   R ready
//  err           out  1   sticky protocol error
// BEHAVIOUR
//  Reset values
//   - arvalid/ic_rd_rdy/d_addr_ok/ic_ret_valid/d_data_ok/err = 0; rready = 0 while reset is high;
//   - araddr/arid/arlen/arsize = 0; outstanding flags, beat count and starve count = 0;
//   - FSM in AR_IDLE.
//  AR FSM: AR_IDLE, AR_SEND
//   - A requester is eligible when its request is high and its outstanding flag is clear.
//   - In AR_IDLE, the grant goes to data if eligible. Exception: when starve_cnt == STARVE_LIMIT
//     and inst is eligible, inst is granted.
//   - On grant:
//     - assert that port's rdy/addr_ok combinationally in the same cycle;
//     - latch arid/araddr/arlen/arsize;
//     - set the outstanding flag;
//     - go to AR_SEND.
//   - AR_SEND: arvalid = 1 and the AR fields are held stable until arvalid && arready, then AR_IDLE.
//     There is no grant in AR_SEND, so at most one AR is in flight.
//     Minimum spacing is 2 cycles per AR.
//  Starvation counter
//   - Increments (saturating) on a data grant while inst is eligible.
//   - Clears on an inst grant.
//  R channel
//   - rready = 1 whenever not in reset.
//   - Beats with rid==0 go to the ic_ret_* ports; beats with rid==1 go to d_data_ok/d_rdata.
//   - Pass-through is combinational (zero-cycle latency).
//   - Outstanding flags clear on the rvalid&&rlast beat for that id.
//   - The inst beat counter increments per inst beat and resets on rlast.
//   - ic_ret_last = rlast.
//  err is set (sticky until reset) on any of:
//   - rid not 0/1;
//   - a beat for an id with no outstanding request (beat is dropped, no ret/data_ok);
//   - inst rlast with count != arlen;
//   - a data beat with rlast = 0.
//  Simultaneous events
//   - An R completion and a new grant for the other id in the same cycle are both honoured.
//   - The same id cannot be set and cleared in one cycle: a grant requires the flag to be clear.
//   - A completion clears the flag at the clock edge; the requester becomes eligible the next cycle.
//  Reset mid-operation
//   - All state clears immediately (asynchronous).
//   - Beats still in flight afterwards raise err, so the slave must be reset together with this block.
// STRUCTURE
//  Shared package:
//   - IC_ID = 4'd0, D_ID = 4'd1;
//   - IC_LINE_TYPE = 3'b100;
//   - ar_state_t {AR_IDLE, AR_SEND};
//   - SIZE_WORD = 3'b010.
//  Sub-module ar_grant: eligibility, priority and the starvation counter; outputs one-hot grant.
// TESTING
//  1. Inst only: line refill at 0x1c000100, arready after 2 cycles, 4 beats rid=0
//     -> arid=0, arlen=3, arsize=2; 4x ic_ret_valid; ic_ret_last on beat 4; err=0.
//  2. Simultaneous: d_req (addr 0x80, size 0) and ic_rd_req in the same cycle
//     -> d_addr_ok first; arsize=0, arid=1; inst is granted in the next AR_IDLE.
//  3. Starvation: d_req held high with back-to-back data returns and inst pending
//     -> inst is granted after exactly 4 data grants; starve_cnt returns to 0.
//  4. Interleaved R: inst burst outstanding, a data beat (rid=1) arrives between inst beats 2 and 3
//     -> d_data_ok pulses once; the inst burst still completes.
//  5. Protocol error: beat with rid=2, then an inst burst with rlast on beat 3
//     -> err=1 after the first and stays set; the stray beat produces no ret.
//  6. Reset asserted while in AR_SEND
//     -> arvalid=0 asynchronously; flags clear; the first grant after release behaves as in test 1.

Source files
------------

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the AXI read-channel arbiter: fixed AXI ids,
// request encodings, AR state type and grant vector bit positions.
package axi_rd_arbiter_pkg;

    localparam logic [3:0] IC_ID        = 4'd0;
    localparam logic [3:0] D_ID         = 4'd1;
    localparam logic [2:0] IC_LINE_TYPE = 3'b100;
    localparam logic [2:0] SIZE_WORD    = 3'b010;

    // Bit positions inside the one-hot grant vector.
    localparam int GNT_IC = 0;
    localparam int GNT_D  = 1;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_SEND = 1'b1
    } ar_state_t;

    // Burst length field for an icache request: a full line for a refill,
    // a single beat for anything else.
    function automatic logic [7:0] ic_arlen(input logic [2:0] rd_type, input int burst_len);
        return (rd_type == IC_LINE_TYPE) ? 8'(burst_len - 1) : 8'd0;
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// Bundle of all request, return and AXI AR/R signals around the arbiter.
// master = the arbiter itself, slave = the cache/core and AXI bridge side.
interface axi_rd_arbiter_if;

    // icache refill port
    logic        ic_rd_req;
    logic [2:0]  ic_rd_type;
    logic [31:0] ic_rd_addr;
    logic        ic_rd_rdy;
    logic        ic_ret_valid;
    logic        ic_ret_last;
    logic [31:0] ic_ret_data;

    // data port
    logic        d_req;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic        d_addr_ok;
    logic        d_data_ok;
    logic [31:0] d_rdata;

    // AXI AR channel
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;

    // AXI R channel
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic        err;

    modport master (
        input  ic_rd_req, ic_rd_type, ic_rd_addr,
        input  d_req, d_size, d_addr,
        input  arready, rid, rdata, rlast, rvalid,
        output ic_rd_rdy, ic_ret_valid, ic_ret_last, ic_ret_data,
        output d_addr_ok, d_data_ok, d_rdata,
        output arid, araddr, arlen, arsize, arvalid, rready, err
    );

    modport slave (
        output ic_rd_req, ic_rd_type, ic_rd_addr,
        output d_req, d_size, d_addr,
        output arready, rid, rdata, rlast, rvalid,
        input  ic_rd_rdy, ic_ret_valid, ic_ret_last, ic_ret_data,
        input  d_addr_ok, d_data_ok, d_rdata,
        input  arid, araddr, arlen, arsize, arvalid, rready, err
    );

endinterface

// File: rtl/axi_rd_arbiter_ar_grant.sv
// AR grant logic: decides which requester may issue an AR this cycle.
// Data normally wins; once data has been granted STARVE_LIMIT times in a row
// while inst was waiting, the next grant is forced to inst.
module axi_rd_arbiter_ar_grant
    import axi_rd_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       idle,
    input  logic       ic_req,
    input  logic       ic_busy,
    input  logic       d_req,
    input  logic       d_busy,
    output logic [1:0] grant
);

    localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic             ic_elig;
    logic             d_elig;
    logic             force_ic;
    logic [CNT_W-1:0] starve_cnt;

    // Saturating increment, capped at the starvation limit.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Eligibility and priority; grants only happen while the AR FSM is idle.
    always_comb begin
        ic_elig  = ic_req && !ic_busy;
        d_elig   = d_req && !d_busy;
        force_ic = ic_elig && (starve_cnt == CNT_MAX);
        grant    = '0;
        if (idle) begin
            if (d_elig && !force_ic) begin
                grant[GNT_D] = 1'b1;
            end else if (ic_elig) begin
                grant[GNT_IC] = 1'b1;
            end
        end
    end

    // Count data grants taken while inst was waiting; an inst grant clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant[GNT_IC]) begin
            starve_cnt <= '0;
        end else if (grant[GNT_D] && ic_elig) begin
            starve_cnt <= sat_inc(starve_cnt);
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read channel between the icache refill port (arid 0) and
// the data port (arid 1). One AR in flight at a time, one outstanding request
// per requester, R beats steered back to their owner by rid with no delay.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int IC_BURST_LEN = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    axi_rd_arbiter_if.master bus
);

    ar_state_t  state;
    logic [1:0] grant;
    logic       ic_busy;
    logic       d_busy;
    logic [7:0] ic_len;
    logic [7:0] ic_beat_cnt;
    logic       ic_beat;
    logic       d_beat;
    logic       r_err;

    axi_rd_arbiter_ar_grant #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_ar_grant (
        .clk    (clk),
        .reset  (reset),
        .idle   (state == AR_IDLE),
        .ic_req (bus.ic_rd_req),
        .ic_busy(ic_busy),
        .d_req  (bus.d_req),
        .d_busy (d_busy),
        .grant  (grant)
    );

    // The accept strobes are the grant itself, so they fire in the request cycle.
    assign bus.ic_rd_rdy = grant[GNT_IC];
    assign bus.d_addr_ok = grant[GNT_D];

    // A beat is only delivered when its id has a request outstanding.
    assign ic_beat = bus.rvalid && (bus.rid == IC_ID) && ic_busy;
    assign d_beat  = bus.rvalid && (bus.rid == D_ID) && d_busy;

    assign bus.rready       = !reset;
    assign bus.ic_ret_valid = ic_beat;
    assign bus.ic_ret_last  = bus.rlast;
    assign bus.ic_ret_data  = bus.rdata;
    assign bus.d_data_ok    = d_beat;
    assign bus.d_rdata      = bus.rdata;

    // AR FSM: latch the granted request, then hold it on AR until accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= AR_IDLE;
            bus.arvalid <= 1'b0;
            bus.arid    <= '0;
            bus.araddr  <= '0;
            bus.arlen   <= '0;
            bus.arsize  <= '0;
            ic_len      <= '0;
        end else begin
            case (state)
                AR_IDLE: begin
                    if (grant[GNT_D]) begin
                        bus.arid    <= D_ID;
                        bus.araddr  <= bus.d_addr;
                        bus.arlen   <= 8'd0;
                        bus.arsize  <= {1'b0, bus.d_size};
                        bus.arvalid <= 1'b1;
                        state       <= AR_SEND;
                    end else if (grant[GNT_IC]) begin
                        bus.arid    <= IC_ID;
                        bus.araddr  <= bus.ic_rd_addr;
                        bus.arlen   <= ic_arlen(bus.ic_rd_type, IC_BURST_LEN);
                        bus.arsize  <= SIZE_WORD;
                        bus.arvalid <= 1'b1;
                        ic_len      <= ic_arlen(bus.ic_rd_type, IC_BURST_LEN);
                        state       <= AR_SEND;
                    end
                end
                AR_SEND: begin
                    if (bus.arready) begin
                        bus.arvalid <= 1'b0;
                        state       <= AR_IDLE;
                    end
                end
                default: state <= AR_IDLE;
            endcase
        end
    end

    // Outstanding flags: set on grant, cleared by the last beat for that id.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ic_busy <= 1'b0;
            d_busy  <= 1'b0;
        end else begin
            if (grant[GNT_IC]) begin
                ic_busy <= 1'b1;
            end else if (ic_beat && bus.rlast) begin
                ic_busy <= 1'b0;
            end
            if (grant[GNT_D]) begin
                d_busy <= 1'b1;
            end else if (d_beat && bus.rlast) begin
                d_busy <= 1'b0;
            end
        end
    end

    // Count inst beats within the current burst; it holds the index of the next beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ic_beat_cnt <= '0;
        end else if (ic_beat) begin
            ic_beat_cnt <= bus.rlast ? 8'd0 : ic_beat_cnt + 8'd1;
        end
    end

    // Protocol checks on every R beat presented by the slave.
    always_comb begin
        r_err = 1'b0;
        if (bus.rvalid) begin
            if ((bus.rid != IC_ID) && (bus.rid != D_ID)) r_err = 1'b1;
            if ((bus.rid == IC_ID) && !ic_busy)          r_err = 1'b1;
            if ((bus.rid == D_ID) && !d_busy)            r_err = 1'b1;
            if (ic_beat && bus.rlast && (ic_beat_cnt != ic_len)) r_err = 1'b1;
            if (d_beat && !bus.rlast)                    r_err = 1'b1;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.err <= 1'b0;
        end else if (r_err) begin
            bus.err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: reset values, a directed vector table, hand
// sequences for starvation / interleaving / errors / async reset, and a
// randomized run against a transaction-level reference model.
module tb_axi_rd_arbiter;
    import axi_rd_arbiter_pkg::*;

    localparam logic [31:0] IA = 32'h1c00_0100;
    localparam logic [31:0] IB = 32'h0000_0200;
    localparam logic [31:0] DA = 32'h0000_0080;
    localparam int          LIMIT = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    axi_rd_arbiter_if bus();

    axi_rd_arbiter #(
        .IC_BURST_LEN(4),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        ic_req;
        logic [2:0]  ic_type;
        logic [31:0] ic_addr;
        logic        d_req;
        logic [1:0]  d_size;
        logic [31:0] d_addr;
        logic        arready;
        logic        rvalid;
        logic [3:0]  rid;
        logic        rlast;
        logic [1:0]  e_gnt;     // {d_addr_ok, ic_rd_rdy}
        logic        e_arvalid;
        logic [3:0]  e_arid;
        logic [31:0] e_araddr;
        logic [7:0]  e_arlen;
        logic [2:0]  e_arsize;
        logic [2:0]  e_ret;     // {d_data_ok, ic last beat, ic_ret_valid}
        logic        e_err;
    } vec_t;

    vec_t tbl [19];

    // Reference model state (transaction level)
    bit          m_busy, m_out_i, m_out_d, m_err;
    int          m_starve, m_cnt, m_ic_len;
    logic [3:0]  m_arid;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_in();
        bus.ic_rd_req = 1'b0; bus.ic_rd_type = 3'b000; bus.ic_rd_addr = 32'h0;
        bus.d_req = 1'b0; bus.d_size = 2'b00; bus.d_addr = 32'h0;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rid = 4'h0; bus.rlast = 1'b0; bus.rdata = 32'h0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic beat(input logic [3:0] id, input logic last, input logic [31:0] data);
        bus.rvalid = 1'b1; bus.rid = id; bus.rlast = last; bus.rdata = data;
    endtask

    task automatic no_beat();
        bus.rvalid = 1'b0; bus.rlast = 1'b0;
    endtask

    // Issue an inst request and complete its AR handshake (2 cycles).
    task automatic ic_grant_and_send(input logic [2:0] ty, input logic [31:0] addr);
        bus.ic_rd_req = 1'b1; bus.ic_rd_type = ty; bus.ic_rd_addr = addr;
        mid(); chk("seq.ic_rdy", 32'(bus.ic_rd_rdy), 1);
        tick();
        bus.ic_rd_req = 1'b0; bus.arready = 1'b1;
        mid(); chk("seq.arvalid", 32'(bus.arvalid), 1);
        tick();
        bus.arready = 1'b0;
    endtask

    task automatic model_reset();
        m_busy = 0; m_out_i = 0; m_out_d = 0; m_err = 0;
        m_starve = 0; m_cnt = 0; m_ic_len = 0;
        m_arid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0;
    endtask

    // One randomized cycle: drive, compare against the model, advance the model.
    task automatic rand_cycle();
        int  pick;
        bit  elig_i, elig_d, gnt_i, gnt_d, beat_i, beat_d;
        bus.ic_rd_req  = ($urandom_range(0, 9) < 6);
        bus.ic_rd_type = ($urandom_range(0, 1) == 1) ? 3'b100 : 3'($urandom_range(0, 7));
        bus.ic_rd_addr = $urandom();
        bus.d_req      = ($urandom_range(0, 9) < 6);
        bus.d_size     = 2'($urandom_range(0, 3));
        bus.d_addr     = $urandom();
        bus.arready    = ($urandom_range(0, 1) == 1);
        bus.rdata      = $urandom();
        bus.rvalid     = 1'b0;
        bus.rid        = 4'($urandom_range(0, 15));
        bus.rlast      = 1'($urandom_range(0, 1));
        pick = $urandom_range(0, 99);
        if (pick < 35 && m_out_i) begin
            bus.rvalid = 1'b1; bus.rid = IC_ID;
            bus.rlast  = (m_cnt >= m_ic_len) ^ ($urandom_range(0, 39) == 0);
        end else if (pick < 60 && m_out_d) begin
            bus.rvalid = 1'b1; bus.rid = D_ID;
            bus.rlast  = ($urandom_range(0, 39) != 0);
        end else if (pick < 62) begin
            bus.rvalid = 1'b1;
        end
        mid();
        elig_i = bus.ic_rd_req && !m_out_i;
        elig_d = bus.d_req && !m_out_d;
        gnt_d  = !m_busy && elig_d && !(m_starve == LIMIT && elig_i);
        gnt_i  = !m_busy && elig_i && !gnt_d;
        beat_i = bus.rvalid && bus.rid == 4'd0 && m_out_i;
        beat_d = bus.rvalid && bus.rid == 4'd1 && m_out_d;
        chk("rnd.ic_rd_rdy", 32'(bus.ic_rd_rdy), 32'(gnt_i));
        chk("rnd.d_addr_ok", 32'(bus.d_addr_ok), 32'(gnt_d));
        chk("rnd.arvalid", 32'(bus.arvalid), 32'(m_busy));
        chk("rnd.arid", 32'(bus.arid), 32'(m_arid));
        chk("rnd.araddr", bus.araddr, m_araddr);
        chk("rnd.arlen", 32'(bus.arlen), 32'(m_arlen));
        chk("rnd.arsize", 32'(bus.arsize), 32'(m_arsize));
        chk("rnd.rready", 32'(bus.rready), 1);
        chk("rnd.ic_ret_valid", 32'(bus.ic_ret_valid), 32'(beat_i));
        if (beat_i) begin
            chk("rnd.ic_ret_last", 32'(bus.ic_ret_last), 32'(bus.rlast));
            chk("rnd.ic_ret_data", bus.ic_ret_data, bus.rdata);
        end
        chk("rnd.d_data_ok", 32'(bus.d_data_ok), 32'(beat_d));
        if (beat_d) chk("rnd.d_rdata", bus.d_rdata, bus.rdata);
        chk("rnd.err", 32'(bus.err), 32'(m_err));
        // advance model to the post-edge state
        if (bus.rvalid) begin
            if (bus.rid > 4'd1) m_err = 1;
            if (bus.rid == 4'd0 && !m_out_i) m_err = 1;
            if (bus.rid == 4'd1 && !m_out_d) m_err = 1;
            if (beat_i && bus.rlast && m_cnt != m_ic_len) m_err = 1;
            if (beat_d && !bus.rlast) m_err = 1;
        end
        if (beat_i) begin
            m_cnt = bus.rlast ? 0 : m_cnt + 1;
            if (bus.rlast) m_out_i = 0;
        end
        if (beat_d && bus.rlast) m_out_d = 0;
        if (m_busy && bus.arready) m_busy = 0;
        if (gnt_d) begin
            m_busy = 1; m_out_d = 1;
            m_arid = 4'd1; m_araddr = bus.d_addr; m_arlen = 8'd0; m_arsize = {1'b0, bus.d_size};
            if (elig_i && m_starve < LIMIT) m_starve++;
        end
        if (gnt_i) begin
            m_busy = 1; m_out_i = 1; m_starve = 0;
            m_ic_len = (bus.ic_rd_type == 3'b100) ? 3 : 0;
            m_arid = 4'd0; m_araddr = bus.ic_rd_addr; m_arlen = 8'(m_ic_len); m_arsize = 3'b010;
        end
        tick();
    endtask

    initial begin
        vec_t v;

        // ---------------- reset values ----------------
        idle_in();
        tick();
        mid();
        chk("rst.arvalid", 32'(bus.arvalid), 0);
        chk("rst.rready", 32'(bus.rready), 0);
        chk("rst.err", 32'(bus.err), 0);
        chk("rst.arid", 32'(bus.arid), 0);
        chk("rst.araddr", bus.araddr, 0);
        chk("rst.arlen", 32'(bus.arlen), 0);
        chk("rst.arsize", 32'(bus.arsize), 0);
        chk("rst.grants", {30'b0, bus.d_addr_ok, bus.ic_rd_rdy}, 0);
        chk("rst.rets", {30'b0, bus.ic_ret_valid, bus.d_data_ok}, 0);
        tick();
        reset = 1'b0;

        // ---------------- directed table: inst refill, then simultaneous requests ----------------
        //          icq ty ica  dq sz da   ard rv rid rl  gnt arv arid araddr arlen arsz ret err
        tbl[0]  = '{1, 4, IA,  0, 0, 0,   0,  0, 0,  0,  1,  0,  0,   0,     0,    0,   0,  0};
        tbl[1]  = '{0, 0, 0,   0, 0, 0,   0,  0, 0,  0,  0,  1,  0,   IA,    3,    2,   0,  0};
        tbl[2]  = '{0, 0, 0,   0, 0, 0,   0,  0, 0,  0,  0,  1,  0,   IA,    3,    2,   0,  0};
        tbl[3]  = '{0, 0, 0,   0, 0, 0,   1,  0, 0,  0,  0,  1,  0,   IA,    3,    2,   0,  0};
        tbl[4]  = '{0, 0, 0,   0, 0, 0,   0,  1, 0,  0,  0,  0,  0,   0,     0,    0,   1,  0};
        tbl[5]  = '{0, 0, 0,   0, 0, 0,   0,  1, 0,  0,  0,  0,  0,   0,     0,    0,   1,  0};
        tbl[6]  = '{0, 0, 0,   0, 0, 0,   0,  1, 0,  0,  0,  0,  0,   0,     0,    0,   1,  0};
        tbl[7]  = '{0, 0, 0,   0, 0, 0,   0,  1, 0,  1,  0,  0,  0,   0,     0,    0,   3,  0};
        tbl[8]  = '{0, 0, 0,   0, 0, 0,   0,  0, 0,  0,  0,  0,  0,   0,     0,    0,   0,  0};
        tbl[9]  = '{1, 4, IB,  1, 0, DA,  0,  0, 0,  0,  2,  0,  0,   0,     0,    0,   0,  0};
        tbl[10] = '{1, 4, IB,  0, 0, 0,   1,  0, 0,  0,  0,  1,  1,   DA,    0,    0,   0,  0};
        tbl[11] = '{1, 4, IB,  0, 0, 0,   0,  0, 0,  0,  1,  0,  0,   0,     0,    0,   0,  0};
        tbl[12] = '{0, 0, 0,   0, 0, 0,   1,  0, 0,  0,  0,  1,  0,   IB,    3,    2,   0,  0};
        tbl[13] = '{0, 0, 0,   0, 0, 0,   0,  1, 1,  1,  0,  0,  0,   0,     0,    0,   4,  0};
        tbl[14] = '{0, 0, 0,   0, 0, 0,   0,  1, 0,  0,  0,  0,  0,   0,     0,    0,   1,  0};
        tbl[15] = '{0, 0, 0,   0, 0, 0,   0,  1, 0,  0,  0,  0,  0,   0,     0,    0,   1,  0};
        tbl[16] = '{0, 0, 0,   0, 0, 0,   0,  1, 0,  0,  0,  0,  0,   0,     0,    0,   1,  0};
        tbl[17] = '{0, 0, 0,   0, 0, 0,   0,  1, 0,  1,  0,  0,  0,   0,     0,    0,   3,  0};
        tbl[18] = '{0, 0, 0,   0, 0, 0,   0,  0, 0,  0,  0,  0,  0,   0,     0,    0,   0,  0};

        for (int i = 0; i < 19; i++) begin
            v = tbl[i];
            bus.ic_rd_req = v.ic_req; bus.ic_rd_type = v.ic_type; bus.ic_rd_addr = v.ic_addr;
            bus.d_req = v.d_req; bus.d_size = v.d_size; bus.d_addr = v.d_addr;
            bus.arready = v.arready; bus.rvalid = v.rvalid; bus.rid = v.rid; bus.rlast = v.rlast;
            bus.rdata = 32'hA000_0000 + 32'(i);
            mid();
            chk($sformatf("tbl%0d.grant", i), {30'b0, bus.d_addr_ok, bus.ic_rd_rdy}, {30'b0, v.e_gnt});
            chk($sformatf("tbl%0d.arvalid", i), 32'(bus.arvalid), 32'(v.e_arvalid));
            if (v.e_arvalid) begin
                chk($sformatf("tbl%0d.arid", i), 32'(bus.arid), 32'(v.e_arid));
                chk($sformatf("tbl%0d.araddr", i), bus.araddr, v.e_araddr);
                chk($sformatf("tbl%0d.arlen", i), 32'(bus.arlen), 32'(v.e_arlen));
                chk($sformatf("tbl%0d.arsize", i), 32'(bus.arsize), 32'(v.e_arsize));
            end
            chk($sformatf("tbl%0d.ret", i),
                {29'b0, bus.d_data_ok, bus.ic_ret_valid & bus.ic_ret_last, bus.ic_ret_valid},
                {29'b0, v.e_ret});
            if (v.e_ret[0]) chk($sformatf("tbl%0d.ic_data", i), bus.ic_ret_data, 32'hA000_0000 + 32'(i));
            if (v.e_ret[2]) chk($sformatf("tbl%0d.d_rdata", i), bus.d_rdata, 32'hA000_0000 + 32'(i));
            chk($sformatf("tbl%0d.err", i), 32'(bus.err), 32'(v.e_err));
            chk($sformatf("tbl%0d.rready", i), 32'(bus.rready), 1);
            tick();
        end

        // ---------------- starvation guard ----------------
        do_reset();
        bus.ic_rd_req = 1'b1; bus.ic_rd_type = 3'b000; bus.ic_rd_addr = 32'h300;
        bus.d_req = 1'b1; bus.d_size = 2'd2; bus.d_addr = 32'h400;
        for (int rnd = 0; rnd < 2; rnd++) begin
            for (int g = 0; g < LIMIT; g++) begin
                mid(); chk("starve.d_grant", {30'b0, bus.d_addr_ok, bus.ic_rd_rdy}, 2);
                tick();
                bus.arready = 1'b1; beat(D_ID, 1'b1, 32'h5000 + 32'(g));
                mid(); chk("starve.d_ret", 32'(bus.d_data_ok), 1);
                chk("starve.d_arid", 32'(bus.arid), 1);
                tick();
                bus.arready = 1'b0; no_beat();
            end
            mid(); chk("starve.ic_forced", {30'b0, bus.d_addr_ok, bus.ic_rd_rdy}, 1);
            tick();
            bus.arready = 1'b1; beat(IC_ID, 1'b1, 32'h6000);
            mid(); chk("starve.ic_arid", 32'(bus.arid), 0);
            chk("starve.ic_arlen", 32'(bus.arlen), 0);
            chk("starve.ic_arsize", 32'(bus.arsize), 2);
            chk("starve.ic_ret", 32'(bus.ic_ret_valid), 1);
            tick();
            bus.arready = 1'b0; no_beat();
        end
        mid(); chk("starve.err", 32'(bus.err), 0);

        // ---------------- data beat interleaved within an inst burst ----------------
        do_reset();
        ic_grant_and_send(3'b100, IA);
        bus.d_req = 1'b1; bus.d_size = 2'd1; bus.d_addr = 32'h84;
        mid(); chk("ilv.d_grant", 32'(bus.d_addr_ok), 1);
        tick();
        bus.d_req = 1'b0; bus.arready = 1'b1; beat(IC_ID, 1'b0, 32'h11);
        mid(); chk("ilv.d_arsize", 32'(bus.arsize), 1);
        chk("ilv.ic1", 32'(bus.ic_ret_valid), 1); chk("ilv.d1", 32'(bus.d_data_ok), 0);
        tick();
        bus.arready = 1'b0; beat(IC_ID, 1'b0, 32'h12);
        mid(); chk("ilv.ic2", 32'(bus.ic_ret_valid), 1); chk("ilv.d2", 32'(bus.d_data_ok), 0);
        tick();
        beat(D_ID, 1'b1, 32'hD0D0);
        mid(); chk("ilv.d_ok", 32'(bus.d_data_ok), 1); chk("ilv.d_rdata", bus.d_rdata, 32'hD0D0);
        chk("ilv.ic_gap", 32'(bus.ic_ret_valid), 0);
        tick();
        beat(IC_ID, 1'b0, 32'h13);
        mid(); chk("ilv.ic3", 32'(bus.ic_ret_valid), 1); chk("ilv.d3", 32'(bus.d_data_ok), 0);
        tick();
        beat(IC_ID, 1'b1, 32'h14);
        mid(); chk("ilv.ic4", 32'(bus.ic_ret_valid), 1); chk("ilv.ic4_last", 32'(bus.ic_ret_last), 1);
        chk("ilv.d4", 32'(bus.d_data_ok), 0);
        tick();
        no_beat();
        mid(); chk("ilv.err", 32'(bus.err), 0);
        tick();

        // ---------------- protocol errors ----------------
        do_reset();
        beat(4'd2, 1'b1, 32'hBAD);
        mid(); chk("err.stray_ic", 32'(bus.ic_ret_valid), 0); chk("err.stray_d", 32'(bus.d_data_ok), 0);
        chk("err.before", 32'(bus.err), 0);
        tick();
        no_beat();
        mid(); chk("err.bad_rid", 32'(bus.err), 1);
        tick();
        ic_grant_and_send(3'b100, IA);
        for (int b = 0; b < 3; b++) begin
            beat(IC_ID, (b == 2), 32'h20 + 32'(b));
            mid(); chk("err.short_ret", 32'(bus.ic_ret_valid), 1); chk("err.sticky", 32'(bus.err), 1);
            tick();
        end
        no_beat();
        mid(); chk("err.sticky_end", 32'(bus.err), 1);
        tick();

        do_reset();
        mid(); chk("err.cleared", 32'(bus.err), 0);
        tick();
        ic_grant_and_send(3'b100, IA);
        for (int b = 0; b < 3; b++) begin
            beat(IC_ID, (b == 2), 32'h30 + 32'(b));
            mid(); chk("err.short_pre", 32'(bus.err), 0);
            tick();
        end
        no_beat();
        mid(); chk("err.short_burst", 32'(bus.err), 1);
        tick();

        do_reset();
        beat(D_ID, 1'b1, 32'h40);
        mid(); chk("err.unreq_drop", 32'(bus.d_data_ok), 0);
        tick();
        no_beat();
        mid(); chk("err.unreq", 32'(bus.err), 1);
        tick();

        do_reset();
        bus.d_req = 1'b1; bus.d_addr = 32'h44; bus.d_size = 2'd2;
        mid(); chk("err.d_grant", 32'(bus.d_addr_ok), 1);
        tick();
        bus.d_req = 1'b0; bus.arready = 1'b1; beat(D_ID, 1'b0, 32'h50);
        mid(); chk("err.d_nolast_ok", 32'(bus.d_data_ok), 1);
        tick();
        bus.arready = 1'b0; no_beat();
        mid(); chk("err.d_nolast", 32'(bus.err), 1);
        tick();

        // ---------------- asynchronous reset while in AR_SEND ----------------
        do_reset();
        bus.ic_rd_req = 1'b1; bus.ic_rd_type = 3'b100; bus.ic_rd_addr = IA;
        mid(); chk("arst.grant", 32'(bus.ic_rd_rdy), 1);
        tick();
        bus.ic_rd_req = 1'b0;
        mid(); chk("arst.send", 32'(bus.arvalid), 1);
        #2 reset = 1'b1;
        #1;
        chk("arst.arvalid", 32'(bus.arvalid), 0);
        chk("arst.rready", 32'(bus.rready), 0);
        chk("arst.araddr", bus.araddr, 0);
        tick();
        reset = 1'b0;
        ic_grant_and_send(3'b100, IA);
        chk("arst.arid", 32'(bus.arid), 0);
        chk("arst.arlen", 32'(bus.arlen), 3);
        chk("arst.araddr2", bus.araddr, IA);
        for (int b = 0; b < 4; b++) begin
            beat(IC_ID, (b == 3), 32'h70 + 32'(b));
            mid(); chk("arst.ret", 32'(bus.ic_ret_valid), 1);
            chk("arst.last", 32'(bus.ic_ret_last), (b == 3) ? 1 : 0);
            tick();
        end
        no_beat();
        mid(); chk("arst.err", 32'(bus.err), 0);
        tick();

        // ---------------- randomized run against the reference model ----------------
        for (int blk = 0; blk < 6; blk++) begin
            do_reset();
            model_reset();
            repeat (400) rand_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
